// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - grants the single pmem port to the I-cache or D-cache, one transaction at a time.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: D-cache always wins ties).
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,
  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state, state_next;
  logic   i_req, d_req, grant_d;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 0 = I-cache was granted last, 1 = D-cache
  logic last_grant;

  assign grant_d = d_req & (~i_req | ~last_grant);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && (i_req || d_req)) begin
      last_grant <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = SERVE_D;
        end else if (i_req) begin
          state_next = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data is shared; each cache qualifies it with its own resp.
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

  always_comb begin
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state)
      SERVE_I: begin
        pmem_read        = icache_pmem_read;
        pmem_address     = icache_pmem_address;
        icache_pmem_resp = pmem_resp;
      end
      SERVE_D: begin
        pmem_write       = dcache_pmem_write;
        pmem_read        = dcache_pmem_read & ~dcache_pmem_write;
        pmem_address     = dcache_pmem_address;
        pmem_wdata       = dcache_pmem_wdata;
        dcache_pmem_resp = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter with a transaction-level ownership model.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          icache_pmem_read;
  logic [AW-1:0] icache_pmem_address;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read;
  logic          dcache_pmem_write;
  logic [AW-1:0] dcache_pmem_address;
  logic [LW-1:0] dcache_pmem_wdata;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the memory port (0 none, 1 I-cache, 2 D-cache).
  int m_owner = 0;
  bit m_last_d = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner  <= 0;
      m_last_d <= 1'b0;
    end else if (m_owner == 0) begin
      if (icache_pmem_read && (dcache_pmem_read || dcache_pmem_write)) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_owner  <= m_last_d ? 1 : 2;
        m_last_d <= !m_last_d;
`else
        m_owner  <= 2;
`endif
      end else if (icache_pmem_read) begin
        m_owner  <= 1;
        m_last_d <= 1'b0;
      end else if (dcache_pmem_read || dcache_pmem_write) begin
        m_owner  <= 2;
        m_last_d <= 1'b1;
      end
    end else if (pmem_resp) begin
      m_owner <= 0;
    end
  end

  logic          exp_read, exp_write, exp_iresp, exp_dresp;
  logic [AW-1:0] exp_addr;
  logic [LW-1:0] exp_wdata;

  always_comb begin
    exp_read  = 1'b0;
    exp_write = 1'b0;
    exp_iresp = 1'b0;
    exp_dresp = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    if (m_owner == 1) begin
      exp_read  = icache_pmem_read;
      exp_addr  = icache_pmem_address;
      exp_iresp = pmem_resp;
    end else if (m_owner == 2) begin
      exp_write = dcache_pmem_write;
      exp_read  = dcache_pmem_read && !dcache_pmem_write;
      exp_addr  = dcache_pmem_address;
      exp_wdata = dcache_pmem_wdata;
      exp_dresp = pmem_resp;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_pmem_read    = 1'b0;
    icache_pmem_address = '0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata   = '0;
    pmem_resp           = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    icache_pmem_read  = 1'b1;
    dcache_pmem_read  = 1'b1;
    dcache_pmem_write = 1'b1;
    icache_pmem_address = 32'h0000_1111;
    dcache_pmem_address = 32'h0000_2222;
    pmem_resp  = 1'b1;
    pmem_rdata = {8{32'hDEAD_BEEF}};
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rw: got %b expected 00", {pmem_read, pmem_write});
    end
    n_checks++;
    if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b00) begin
      n_fail++; $display("FAIL reset_resp: got %b expected 00", {icache_pmem_resp, dcache_pmem_resp});
    end
    n_checks++;
    if (pmem_address !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 0", pmem_address);
    end
    n_checks++;
    if (icache_pmem_rdata !== {8{32'hDEAD_BEEF}} || dcache_pmem_rdata !== {8{32'hDEAD_BEEF}}) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected %h", icache_pmem_rdata, {8{32'hDEAD_BEEF}});
    end
    clear_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_i_fill();
    logic [LW-1:0] fill;
    fill = {8{32'h1234_5678}};
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 32'h0000_1000;
    @(negedge clk);
    n_checks++;
    if (pmem_read !== 1'b0) begin
      n_fail++; $display("FAIL ifill_arb_cycle: pmem_read got %b expected 0", pmem_read);
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_1000 || icache_pmem_resp !== 1'b0) begin
        n_fail++; $display("FAIL ifill_cycle%0d: read=%b addr=%h iresp=%b expected 1 00001000 0",
                           c, pmem_read, pmem_address, icache_pmem_resp);
      end
    end
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = fill;
    @(negedge clk);
    n_checks++;
    if (icache_pmem_resp !== 1'b1 || dcache_pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL ifill_resp: iresp=%b dresp=%b expected 1 0", icache_pmem_resp, dcache_pmem_resp);
    end
    n_checks++;
    if (icache_pmem_rdata !== fill) begin
      n_fail++; $display("FAIL ifill_rdata: got %h expected %h", icache_pmem_rdata, fill);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (pmem_read !== 1'b0 || icache_pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL ifill_idle: read=%b iresp=%b expected 0 0", pmem_read, icache_pmem_resp);
    end
  endtask

  task automatic test_d_wb_refill();
    tick();
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 32'h0000_2000;
    dcache_pmem_wdata   = {8{32'hA5A5_A5A5}};
    tick();
    @(negedge clk);
    n_checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h0000_2000) begin
      n_fail++; $display("FAIL wb_cmd: write=%b read=%b addr=%h expected 1 0 00002000",
                         pmem_write, pmem_read, pmem_address);
    end
    n_checks++;
    if (pmem_wdata !== {8{32'hA5A5_A5A5}}) begin
      n_fail++; $display("FAIL wb_wdata: got %h expected %h", pmem_wdata, {8{32'hA5A5_A5A5}});
    end
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL wb_resp: dresp=%b iresp=%b expected 1 0", dcache_pmem_resp, icache_pmem_resp);
    end
    tick();
    pmem_resp           = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 32'h0000_3000;
    @(negedge clk);
    n_checks++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      n_fail++; $display("FAIL wb_gap: read/write got %b expected 00", {pmem_read, pmem_write});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_3000) begin
      n_fail++; $display("FAIL refill_cmd: read=%b write=%b addr=%h expected 1 0 00003000",
                         pmem_read, pmem_write, pmem_address);
    end
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dcache_pmem_resp !== 1'b1) begin
      n_fail++; $display("FAIL refill_resp: dresp got %b expected 1", dcache_pmem_resp);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    logic [AW-1:0] want_addr;
    bit            want_d;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 32'h0000_4000;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 32'h0000_5000;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      want_d = (t % 2 == 0);
`else
      want_d = 1'b1;
`endif
      want_addr = want_d ? 32'h0000_5000 : 32'h0000_4000;
      tick();
      @(negedge clk);
      n_checks++;
      if (pmem_read !== 1'b1 || pmem_address !== want_addr) begin
        n_fail++; $display("FAIL tie_grant%0d: read=%b addr=%h expected 1 %h", t, pmem_read, pmem_address, want_addr);
      end
      tick();
      pmem_resp = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dcache_pmem_resp !== want_d || icache_pmem_resp !== !want_d) begin
        n_fail++; $display("FAIL tie_resp%0d: dresp=%b iresp=%b expected %b %b",
                           t, dcache_pmem_resp, icache_pmem_resp, want_d, !want_d);
      end
      tick();
      pmem_resp = 1'b0;
      @(negedge clk);
      n_checks++;
      if (pmem_read !== 1'b0) begin
        n_fail++; $display("FAIL tie_idle%0d: read got %b expected 0", t, pmem_read);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_transaction();
    tick();
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 32'h0000_6000;
    tick();
    @(negedge clk);
    n_checks++;
    if (pmem_write !== 1'b1) begin
      n_fail++; $display("FAIL rmid_serve: write got %b expected 1", pmem_write);
    end
    tick();
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    pmem_resp = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dcache_pmem_resp !== 1'b0 || pmem_write !== 1'b0) begin
      n_fail++; $display("FAIL rmid_drop: dresp=%b write=%b expected 0 0", dcache_pmem_resp, pmem_write);
    end
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pmem_write !== 1'b1 || pmem_address !== 32'h0000_6000) begin
      n_fail++; $display("FAIL rmid_rearb: write=%b addr=%h expected 1 00006000", pmem_write, pmem_address);
    end
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dcache_pmem_resp !== 1'b1) begin
      n_fail++; $display("FAIL rmid_resp: dresp got %b expected 1", dcache_pmem_resp);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      icache_pmem_read    = ($urandom_range(0, 2) != 0);
      dcache_pmem_read    = ($urandom_range(0, 2) == 0);
      dcache_pmem_write   = ($urandom_range(0, 2) == 0);
      icache_pmem_address = $urandom;
      dcache_pmem_address = $urandom;
      for (int k = 0; k < 8; k++) begin
        dcache_pmem_wdata[k*32 +: 32] = $urandom;
        pmem_rdata[k*32 +: 32]        = $urandom;
      end
      pmem_resp = ($urandom_range(0, 3) == 0);
      rst_n     = ($urandom_range(0, 60) != 0);
      @(negedge clk);
      n_checks++;
      if ({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp} !==
          {exp_read, exp_write, exp_iresp, exp_dresp}) begin
        n_fail++; $display("FAIL rand_ctrl cycle %0d: rd/wr/iresp/dresp got %b expected %b", c,
                           {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp},
                           {exp_read, exp_write, exp_iresp, exp_dresp});
      end
      n_checks++;
      if (pmem_address !== exp_addr || pmem_wdata !== exp_wdata) begin
        n_fail++; $display("FAIL rand_data cycle %0d: addr %h wdata %h expected %h %h", c,
                           pmem_address, pmem_wdata, exp_addr, exp_wdata);
      end
      n_checks++;
      if (icache_pmem_rdata !== pmem_rdata || dcache_pmem_rdata !== pmem_rdata) begin
        n_fail++; $display("FAIL rand_rdata cycle %0d: got %h expected %h", c, dcache_pmem_rdata, pmem_rdata);
      end
      tick();
    end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    pmem_rdata = '0;
    rst_n      = 1'b0;
    #1;
    test_reset();
    test_single_i_fill();
    test_d_wb_refill();
    test_simultaneous();
    test_reset_mid_transaction();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
